alu_64bit: RTL and testbench
============================

// Module: alu_64bit
// PURPOSE
//   Registered 64-bit integer ALU for the LEGv8 datapath EX stage.
//   - Applies a 4-bit ALU-control operation to operands a and b.
//   - Registers the result and a zero flag; the zero flag drives CBZ/branch decisions.
//   - Operands are treated as unsigned bit vectors; add/sub wrap modulo 2^WIDTH.
// PARAMETERS
//   WIDTH  64  data path width in bits; all arithmetic is modulo 2^WIDTH
// PORTS
//   clk         in   1      single clock; all state updates on its rising edge
//   rst         in   1      asynchronous, active-high reset
//   alu_op      in   4      ALU control operation code (see BEHAVIOUR)
//   a           in   WIDTH  operand A (first source register)
//   b           in   WIDTH  operand B (second source register / immediate)
//   zero        out  1      registered: 1 when alu_result == 0
//   alu_result  out  WIDTH  registered operation result
//   flags       out  4      {N,Z,V,C}; present only with ALU_FLAGS_EN
// BEHAVIOUR
//   - Reset: while rst=1, asynchronously alu_result=0 and zero=1; flags=4'b0100 if enabled.
//   - Latency: exactly 1 cycle. Inputs are sampled at rising clk edge k and are visible at
//     the outputs after edge k. There is no handshake, and a new operation is accepted every cycle.
//   - Opcode map:
//       0000 AND   a & b
//       0001 OR    a | b
//       0010 ADD   a + b
//       0110 SUB   a - b, computed as a + ~b + 1
//       0111 PASSB b (CBZ: zero tests b)
//       1000 ADD   alias of 0010, identical result and flags
//       1100 NOR   ~(a | b)
//       other      alu_result=0, zero=1
//   - zero is derived from the next alu_result value (|result == 0) and registered with it.
//     It is never one cycle stale relative to alu_result.
//   - Wrap-around:
//       ADD with carry out: the result keeps the low WIDTH bits only.
//       SUB with a<b: the result is the two's-complement wrap, e.g. 0-1 = all ones.
//   - rst asserted mid-operation discards the pending result.
//     The first valid result appears 1 edge after rst deasserts.
//   - X/undefined alu_op bits are treated as "other".
// CONFIGURATION
//   - ALU_FLAGS_EN defined: adds the flags output, registered alongside alu_result.
//       N = result[WIDTH-1]
//       Z = zero
//       C = adder carry-out (ADD) / no-borrow, i.e. a>=b unsigned (SUB); 0 for logic ops
//       V = signed overflow (ADD/SUB only); 0 for logic ops
//   - ALU_FLAGS_EN undefined: no flags port and no carry/overflow logic. Other behaviour is identical.
// STRUCTURE
//   - Shared package alu_pkg:
//       localparams ALU_AND, ALU_OR, ALU_ADD, ALU_ADD_ALT, ALU_SUB, ALU_PASSB, ALU_NOR
//       typedef of the 4-bit alu_op_t
//   - Sub-module alu_addsub: combinational WIDTH-bit add/subtract (sub input inverts b and
//     sets carry-in). Outputs sum, carry_out, overflow.
//   - Top level: opcode mux, zero-detect, output registers.
// TESTING
//   - op=0010, a=50,  b=25  -> after 1 edge: alu_result=75, zero=0
//   - op=1000, a=50,  b=25  -> alu_result=75, zero=0
//   - op=0000, a=7,   b=10  -> alu_result=2,  zero=0
//   - op=0000, a=8,   b=0   -> alu_result=0,  zero=1
//   - op=0001, a=76,  b=28  -> alu_result=92, zero=0
//   - op=0110, a=100, b=36  -> alu_result=64, zero=0
//   - op=0111, a=27,  b=5   -> alu_result=5,  zero=0
//   - op=0111, b=0          -> alu_result=0,  zero=1
//   - Wrap: op=0010, a=all ones, b=1 -> alu_result=0, zero=1, C=1 (flags build)
//   - Wrap: op=0110, a=0, b=1 -> alu_result=all ones, N=1, C=0
//   - Reset: assert rst asynchronously mid-stream -> alu_result=0, zero=1 immediately,
//     without waiting for a clk edge. Deassert -> first new result after the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the LEGv8 EX-stage ALU.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND     = 4'b0000;
  localparam alu_op_t ALU_OR      = 4'b0001;
  localparam alu_op_t ALU_ADD     = 4'b0010;
  localparam alu_op_t ALU_SUB     = 4'b0110;
  localparam alu_op_t ALU_PASSB   = 4'b0111;
  localparam alu_op_t ALU_ADD_ALT = 4'b1000;
  localparam alu_op_t ALU_NOR     = 4'b1100;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor; subtract is a + ~b + 1.
// Carry-out and overflow exist only when ALU_FLAGS_EN is defined.
module alu_addsub #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum
`ifdef ALU_FLAGS_EN
  ,
  output logic             o_carry_out,
  output logic             o_overflow
`endif
);

  logic [WIDTH-1:0] w_b_eff;

  assign w_b_eff = i_sub ? ~i_b : i_b;

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] w_sum_ext;

  assign w_sum_ext   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum       = w_sum_ext[WIDTH-1:0];
  assign o_carry_out = w_sum_ext[WIDTH];
  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign o_overflow  = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                       (w_sum_ext[WIDTH-1] != i_a[WIDTH-1]);
`else
  assign o_sum = i_a + w_b_eff + {{(WIDTH-1){1'b0}}, i_sub};
`endif

endmodule

// File: rtl/alu_64bit.sv
// Registered 64-bit ALU (one-cycle latency) with zero flag for CBZ/branch decisions.
// Define ALU_FLAGS_EN to add the registered {N,Z,V,C} flags output.
module alu_64bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  alu_op_t          alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             zero,
  output logic [WIDTH-1:0] alu_result
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  logic [WIDTH-1:0] w_sum_p0;
  logic             w_sub_p0;
  logic [WIDTH-1:0] w_result_p0;
  logic             w_zero_p0;
  logic             w_is_arith_p0;

  logic [WIDTH-1:0] r_result_p1;
  logic             r_zero_p1;

  assign w_sub_p0 = (alu_op == ALU_SUB);

`ifdef ALU_FLAGS_EN
  logic       w_carry_p0;
  logic       w_ovf_p0;
  logic [3:0] w_flags_p0;
  logic [3:0] r_flags_p1;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a         (a),
    .i_b         (b),
    .i_sub       (w_sub_p0),
    .o_sum       (w_sum_p0),
    .o_carry_out (w_carry_p0),
    .o_overflow  (w_ovf_p0)
  );
`else
  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a   (a),
    .i_b   (b),
    .i_sub (w_sub_p0),
    .o_sum (w_sum_p0)
  );
`endif

  // Unknown or X opcodes fall to the default arm and yield zero.
  always_comb begin
    w_result_p0   = '0;
    w_is_arith_p0 = 1'b0;
    case (alu_op)
      ALU_AND:   w_result_p0 = a & b;
      ALU_OR:    w_result_p0 = a | b;
      ALU_NOR:   w_result_p0 = ~(a | b);
      ALU_PASSB: w_result_p0 = b;
      ALU_ADD, ALU_ADD_ALT, ALU_SUB: begin
        w_result_p0   = w_sum_p0;
        w_is_arith_p0 = 1'b1;
      end
      default:   w_result_p0 = '0;
    endcase
  end

  assign w_zero_p0 = ~|w_result_p0;

`ifdef ALU_FLAGS_EN
  assign w_flags_p0 = {w_result_p0[WIDTH-1], w_zero_p0,
                       w_is_arith_p0 & w_ovf_p0, w_is_arith_p0 & w_carry_p0};
`endif

  // ---- p0 -> p1 output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result_p1 <= '0;
      r_zero_p1   <= 1'b1;
`ifdef ALU_FLAGS_EN
      r_flags_p1  <= 4'b0100;
`endif
    end else begin
      r_result_p1 <= w_result_p0;
      r_zero_p1   <= w_zero_p0;
`ifdef ALU_FLAGS_EN
      r_flags_p1  <= w_flags_p0;
`endif
    end
  end

  assign alu_result = r_result_p1;
  assign zero       = r_zero_p1;
`ifdef ALU_FLAGS_EN
  assign flags      = r_flags_p1;
`else
  logic w_unused_arith;
  assign w_unused_arith = w_is_arith_p0;
`endif

endmodule

// File: tb/tb_alu_64bit.sv
// Scoreboard bench for alu_64bit: driver pushes hand-computed expectations,
// a monitor pops and compares one edge later. Flags checked when ALU_FLAGS_EN.
module tb_alu_64bit;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   alu_op = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         zero;
  logic [W-1:0] alu_result;
`ifdef ALU_FLAGS_EN
  logic [3:0]   flags;
`endif

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic         z;
    logic [3:0]   fl;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_64bit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_op     (alu_op),
    .a          (a),
    .b          (b),
    .zero       (zero),
    .alu_result (alu_result)
`ifdef ALU_FLAGS_EN
    ,
    .flags      (flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int id,
                       input logic [W-1:0] res_exp, input logic z_exp, input logic [3:0] fl_exp);
    n_vec++;
    if (alu_result !== res_exp || zero !== z_exp) begin
      n_err++;
      $display("FAIL %s#%0d: result=%h zero=%b, required result=%h zero=%b",
               name, id, alu_result, zero, res_exp, z_exp);
    end
`ifdef ALU_FLAGS_EN
    else if (flags !== fl_exp) begin
      n_err++;
      $display("FAIL %s#%0d flags: got %b, required %b", name, id, flags, fl_exp);
    end
`else
    else if (fl_exp === 4'bxxxx) begin
      n_err++;
    end
`endif
  endtask

  task automatic apply(input int id, input logic [3:0] op, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] res,
                       input logic z, input logic [3:0] fl);
    exp_t e;
    @(negedge clk);
    alu_op = op;
    a      = va;
    b      = vb;
    e.id = id; e.res = res; e.z = z; e.fl = fl;
    sb.push_back(e);
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: output of the op sampled at an edge is checked 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0 && !rst) begin
        e = sb.pop_front();
        check("vec", e.id, e.res, e.z, e.fl);
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2 check("reset_init", 0, '0, 1'b1, 4'b0100);
    @(negedge clk);
    rst = 1'b0;

    //   id op       a                        b                        result                   z     {N,Z,V,C}
    apply(1,  4'b0010, 64'd50,                64'd25,                  64'd75,                  1'b0, 4'b0000);
    apply(2,  4'b1000, 64'd50,                64'd25,                  64'd75,                  1'b0, 4'b0000);
    apply(3,  4'b0000, 64'd7,                 64'd10,                  64'd2,                   1'b0, 4'b0000);
    apply(4,  4'b0000, 64'd8,                 64'd0,                   64'd0,                   1'b1, 4'b0100);
    apply(5,  4'b0001, 64'd76,                64'd28,                  64'd92,                  1'b0, 4'b0000);
    apply(6,  4'b0110, 64'd100,               64'd36,                  64'd64,                  1'b0, 4'b0001);
    apply(7,  4'b0111, 64'd27,                64'd5,                   64'd5,                   1'b0, 4'b0000);
    apply(8,  4'b0111, 64'd99,                64'd0,                   64'd0,                   1'b1, 4'b0100);
    apply(9,  4'b0010, ONES,                  64'd1,                   64'd0,                   1'b1, 4'b0101);
    apply(10, 4'b0110, 64'd0,                 64'd1,                   ONES,                    1'b0, 4'b1000);
    apply(11, 4'b1100, 64'h0000_0000_0000_00FF, 64'hFF00_0000_0000_0000, 64'h00FF_FFFF_FFFF_FF00, 1'b0, 4'b0000);
    apply(12, 4'b0011, 64'd5,                 64'd5,                   64'd0,                   1'b1, 4'b0100);
    apply(13, 4'b0010, ~MSB,                  64'd1,                   MSB,                     1'b0, 4'b1010);
    apply(14, 4'b0110, MSB,                   64'd1,                   ~MSB,                    1'b0, 4'b0011);
    apply(15, 4'b0110, 64'd5,                 64'd5,                   64'd0,                   1'b1, 4'b0101);
    apply(16, 4'b1111, 64'd12,                64'd34,                  64'd0,                   1'b1, 4'b0100);
    apply(17, 4'bxxxx, 64'd0,                 64'd5,                   64'd0,                   1'b1, 4'b0100);
    apply(18, 4'b1000, ONES,                  ONES,                    ONES - 64'd1,            1'b0, 4'b1001);
    drain();

    // Establish a non-zero result, then reset asynchronously between edges.
    apply(19, 4'b0010, 64'd50,                64'd25,                  64'd75,                  1'b0, 4'b0000);
    drain();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("reset_async", 19, '0, 1'b1, 4'b0100);
    @(negedge clk);
    alu_op = 4'b0010; a = 64'd3; b = 64'd4;
    @(posedge clk);
    #1 check("reset_hold", 19, '0, 1'b1, 4'b0100);
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_release", 19, '0, 1'b1, 4'b0100);
    begin
      exp_t e;
      e.id = 20; e.res = 64'd7; e.z = 1'b0; e.fl = 4'b0000;
      sb.push_back(e);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
